// File: rtl/pipe_sequencer.sv
// pipe_sequencer
//   Control block for the 3-stage pipeline (fetch, decode/register-read, execute/writeback).
//   It sequences post-reset fill, normal run, RAW-hazard stalls, halt/drain and resume.
//
// Ports
//   clk          in   clock, all state updates on rising edge
//   reset        in   synchronous, active-high
//   dec_valid    in   decode stage holds a real instruction
//   dec_rs1/2    in   decode source registers
//   dec_use_rs1/2 in  instruction reads rs1 / rs2
//   halt_req     in   decode stage holds a halt instruction
//   resume       in   single-cycle restart request (honoured only in HALTED)
//   ex_rd/ex_wen in   destination and write enable in the execute stage
//   wb_rd/wb_wen in   destination and write enable in writeback
//   pc_en        out  PC may advance
//   fetch_en     out  fetch register may load
//   bubble       out  decode register latches reg_wr_en=0 (NOP)
//   halted       out  pipeline halted and drained (registered)
//   stall_count  out  saturating count of hazard-stall cycles (registered)
//
// state  | meaning
// FILL   | program memory / fetch register filling, bubbles issued
// RUN    | normal issue, stalls on RAW hazards, accepts halt
// DRAIN  | in-flight instructions retire, nothing new issued
// HALTED | drained and idle, waiting for resume

module pipe_sequencer #(
    parameter int FILL_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [4:0]           dec_rs1,
    input  logic [4:0]           dec_rs2,
    input  logic                 dec_use_rs1,
    input  logic                 dec_use_rs2,
    input  logic                 halt_req,
    input  logic                 resume,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_wen,
    input  logic [4:0]           wb_rd,
    input  logic                 wb_wen,
    output logic                 pc_en,
    output logic                 fetch_en,
    output logic                 bubble,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int MAX_CYC = (FILL_CYCLES > DRAIN_CYCLES) ? FILL_CYCLES : DRAIN_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            stall_inc;
    logic            m1, m2, hz;
    logic            pc_en_s, fetch_en_s, bubble_s;

    // No write-through in the register file, so any in-flight writer of a
    // source register forces a stall. x0 is hardwired and never conflicts.
    assign m1 = dec_use_rs1 && (dec_rs1 != 5'd0) &&
                ((ex_wen && (ex_rd == dec_rs1)) || (wb_wen && (wb_rd == dec_rs1)));
    assign m2 = dec_use_rs2 && (dec_rs2 != 5'd0) &&
                ((ex_wen && (ex_rd == dec_rs2)) || (wb_wen && (wb_rd == dec_rs2)));
    assign hz = dec_valid && (m1 || m2);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        stall_inc  = 1'b0;
        pc_en_s    = 1'b0;
        fetch_en_s = 1'b0;
        bubble_s   = 1'b1;
        case (state)
            FILL: begin
                pc_en_s    = 1'b1;
                fetch_en_s = 1'b1;
                if (cnt == '0) state_n = RUN;
                else           cnt_n   = cnt - 1'b1;
            end
            RUN: begin
                if (hz) begin
                    stall_inc = 1'b1;
                end else if (halt_req) begin
                    // halt instruction itself is turned into a bubble
                    state_n = DRAIN;
                    cnt_n   = CW'(DRAIN_CYCLES - 1);
                end else begin
                    pc_en_s    = 1'b1;
                    fetch_en_s = 1'b1;
                    bubble_s   = 1'b0;
                end
            end
            DRAIN: begin
                if (cnt == '0) state_n = HALTED;
                else           cnt_n   = cnt - 1'b1;
            end
            HALTED: begin
                if (resume) begin
                    state_n = FILL;
                    cnt_n   = CW'(FILL_CYCLES - 1);
                end
            end
            default: begin
                state_n = FILL;
                cnt_n   = CW'(FILL_CYCLES - 1);
            end
        endcase
    end

    // Reset overrides the combinational outputs immediately, not just on the edge.
    assign pc_en    = pc_en_s    && !reset;
    assign fetch_en = fetch_en_s && !reset;
    assign bubble   = bubble_s   || reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            cnt         <= CW'(FILL_CYCLES - 1);
            stall_count <= '0;
            halted      <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            halted <= (state_n == HALTED);
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer
//   Directed, self-checking bench for pipe_sequencer. Each cycle the expected
//   output tuple is pushed to a scoreboard queue as the stimulus is driven and
//   popped and compared when the outputs are sampled on the falling edge.

module tb_pipe_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2;
    logic        dec_use_rs1, dec_use_rs2;
    logic        halt_req, resume;
    logic [4:0]  ex_rd, wb_rd;
    logic        ex_wen, wb_wen;
    logic        pc_en, fetch_en, bubble, halted;
    logic [15:0] stall_count;

    pipe_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .halt_req    (halt_req),
        .resume      (resume),
        .ex_rd       (ex_rd),
        .ex_wen      (ex_wen),
        .wb_rd       (wb_rd),
        .wb_wen      (wb_wen),
        .pc_en       (pc_en),
        .fetch_en    (fetch_en),
        .bubble      (bubble),
        .halted      (halted),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    pc;
        int    fe;
        int    bub;
        int    hlt;
        int    sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    // One cycle: push expectation, sample at negedge, then move to posedge+1.
    task automatic cyc(input string tag, input int pc, input int bub, input int hlt, input int sc);
        exp_t e;
        e.tag = tag; e.pc = pc; e.fe = pc; e.bub = bub; e.hlt = hlt; e.sc = sc;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check({e.tag, ".pc_en"},       int'(pc_en),       e.pc);
        check({e.tag, ".fetch_en"},    int'(fetch_en),    e.fe);
        check({e.tag, ".bubble"},      int'(bubble),      e.bub);
        check({e.tag, ".halted"},      int'(halted),      e.hlt);
        check({e.tag, ".stall_count"}, int'(stall_count), e.sc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        halt_req = 0; resume = 0; ex_rd = 0; ex_wen = 0; wb_rd = 0; wb_wen = 0;
    endtask

    // rs1=5 read while execute stage writes r5
    task automatic hz_ex5();
        idle_in();
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1; ex_rd = 5; ex_wen = 1;
    endtask

    initial begin
        reset = 1;
        idle_in();
        @(posedge clk);
        #1;

        // reset held, then release: exactly two fill cycles then run
        repeat (3) cyc("reset", 0, 1, 0, 0);
        reset = 0;
        cyc("fill0", 1, 1, 0, 0);
        cyc("fill1", 1, 1, 0, 0);
        cyc("run0", 1, 0, 0, 0);

        // hazard through execute, then through writeback
        hz_ex5();
        cyc("hz_ex", 0, 1, 0, 0);
        idle_in();
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1; wb_rd = 5; wb_wen = 1;
        cyc("hz_wb", 0, 1, 0, 1);
        idle_in();
        cyc("run_after_hz", 1, 0, 0, 2);

        // non-hazard cases
        dec_valid = 1; dec_rs2 = 0; dec_use_rs2 = 1; ex_rd = 0; ex_wen = 1;
        cyc("r0_no_hz", 1, 0, 0, 2);
        idle_in();
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1; ex_rd = 5; ex_wen = 0;
        cyc("no_wen", 1, 0, 0, 2);
        ex_wen = 1; ex_rd = 21;
        cyc("addr_bit4", 1, 0, 0, 2);
        ex_rd = 5; dec_use_rs1 = 0;
        cyc("no_use", 1, 0, 0, 2);
        dec_use_rs1 = 1; dec_valid = 0;
        cyc("not_valid", 1, 0, 0, 2);

        // rs2 hazard through writeback
        idle_in();
        dec_valid = 1; dec_rs2 = 7; dec_use_rs2 = 1; wb_rd = 7; wb_wen = 1;
        cyc("hz_rs2", 0, 1, 0, 2);
        idle_in();
        cyc("run1", 1, 0, 0, 3);

        // halt: one bubble, two drain, halted on the 4th cycle
        halt_req = 1;
        cyc("halt", 0, 1, 0, 3);
        halt_req = 1;                    // ignored outside RUN
        cyc("drain0", 0, 1, 0, 3);
        halt_req = 0;
        cyc("drain1", 0, 1, 0, 3);
        cyc("halted0", 0, 1, 1, 3);
        halt_req = 1;
        cyc("halted1", 0, 1, 1, 3);
        halt_req = 0;

        // resume: halted drops next cycle, two fill cycles (hazards ignored), then run
        resume = 1;
        cyc("resume", 0, 1, 1, 3);
        resume = 0;
        hz_ex5();
        cyc("rfill0", 1, 1, 0, 3);
        cyc("rfill1", 1, 1, 0, 3);
        idle_in();
        cyc("rrun", 1, 0, 0, 3);
        resume = 1;
        cyc("resume_in_run", 1, 0, 0, 3);
        resume = 0;
        cyc("rrun2", 1, 0, 0, 3);

        // halt together with hazard: stall first, halt on first clean cycle
        hz_ex5(); halt_req = 1;
        cyc("halt_hz", 0, 1, 0, 3);
        idle_in(); halt_req = 1;
        cyc("halt2", 0, 1, 0, 4);
        halt_req = 0;

        // reset in DRAIN with counter=1: halted never asserts
        reset = 1;
        cyc("rst_drain", 0, 1, 0, 4);
        cyc("rst_hold", 0, 1, 0, 0);
        reset = 0;
        cyc("pfill0", 1, 1, 0, 0);
        cyc("pfill1", 1, 1, 0, 0);
        cyc("prun", 1, 0, 0, 0);

        // saturation of stall_count
        hz_ex5();
        repeat (65533) @(posedge clk);
        #1;
        cyc("sat0", 0, 1, 0, 65533);
        cyc("sat1", 0, 1, 0, 65534);
        cyc("sat2", 0, 1, 0, 65535);
        cyc("sat3", 0, 1, 0, 65535);
        idle_in();
        cyc("sat_run", 1, 0, 0, 65535);
        cyc("sat_hold", 1, 0, 0, 65535);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
